// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its core.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the control unit (master) and the mult/div sequencer (slave).
interface mult_div_ctrl_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             high_write;
  logic             low_write;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, high_write, low_write, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, high_write, low_write, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/mult_div_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one step per cycle.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // mult: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
  // div:  a_q is {remainder, dividend/quotient}, b_q the divisor.
  logic                 op_q;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;

  always_comb begin
    a_d    = a_q;
    acc_d  = acc_q;
    b_d    = b_q;
    rem_sh = a_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, b_q};
    if (load_i) begin
      a_d   = {{WIDTH{1'b0}}, a_i};
      b_d   = b_i;
      acc_d = '0;
    end else if (step_i) begin
      if (op_q == OP_MULT) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else if (!diff[WIDTH]) begin
        a_d = {diff[WIDTH-1:0], a_q[WIDTH-2:0], 1'b1};
      end else begin
        a_d = {rem_sh[WIDTH-1:0], a_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) op_q <= op_i;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign hi_o = (op_q == OP_MULT) ? acc_q[2*WIDTH-1:WIDTH] : a_q[2*WIDTH-1:WIDTH];
  assign lo_o = (op_q == OP_MULT) ? acc_q[WIDTH-1:0]       : a_q[WIDTH-1:0];

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer for the shared signed mult/div unit: FSM, step counter, sign handling, HI/LO handshake.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q;
  logic               sign_q;
  logic               rsign_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;
  logic               hw_q;
  logic               lw_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic               div_by_zero;
  logic               core_load;
  logic               core_step;

  assign div_by_zero = (bus.op == OP_DIV) && (bus.src_b == '0);
  assign core_load   = (state_q == IDLE) && bus.start && !div_by_zero;
  assign core_step   = (state_q == MULT) || (state_q == DIV);

  always_comb begin
    a_mag       = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
    b_mag       = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
    prod_mag    = {core_hi, core_lo};
    prod_signed = sign_q ? -prod_mag : prod_mag;
    if (op_q == OP_MULT) begin
      hi_d = prod_signed[2*WIDTH-1:WIDTH];
      lo_d = prod_signed[WIDTH-1:0];
    end else begin
      hi_d = rsign_q ? -core_hi : core_hi;
      lo_d = sign_q  ? -core_lo : core_lo;
    end
  end

  mult_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .load_i (core_load),
    .step_i (core_step),
    .op_i   (bus.op),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  // The DONE state drives the one-cycle pulses, so they appear one edge after the last step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hw_q    <= 1'b0;
      lw_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      hw_q   <= 1'b0;
      lw_q   <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            sign_q  <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
            rsign_q <= bus.src_a[WIDTH-1];
            zero_q  <= div_by_zero;
            if (div_by_zero) begin
              state_q <= DONE;
            end else begin
              state_q <= (bus.op == OP_MULT) ? MULT : DIV;
              busy_q  <= 1'b1;
            end
          end
        end
        MULT, DIV: begin
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          dz_q    <= zero_q;
          if (!zero_q) begin
            hw_q <= 1'b1;
            lw_q <= 1'b1;
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
          zero_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.high_write = hw_q;
  assign bus.low_write  = lw_q;
  assign bus.div_zero   = dz_q;
  assign bus.hi_out     = hi_q;
  assign bus.lo_out     = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: expected HI/LO queued at start, checked on done.
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    string        name;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULT) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                       input string name);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
    sb_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.op = ~op; bus.src_a = $urandom; bus.src_b = $urandom;
    checks++;
    if ({bus.done, bus.high_write, bus.low_write} !== 3'b000) begin
      errors++;
      $display("FAIL %s pulse_len: done/hw/lw=%b required 000", name,
               {bus.done, bus.high_write, bus.low_write});
    end
    checks++;
    if (bus.busy !== !edz) begin
      errors++;
      $display("FAIL %s busy_start: busy=%b required %b", name, bus.busy, !edz);
    end
  endtask

  task automatic wait_done(input bit inject, input int exp_lat, input int exp_busy);
    int   n = 0;
    int   busy_cnt;
    exp_t e;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && n < 100) begin
      bus.start = 1'b0;
      if (inject && (n == 5 || n == 20)) begin
        bus.start = 1'b1; bus.op = 1'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
      end
      @(posedge clock); #1;
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.start = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    e = sb_q.pop_front();
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1 within 100 cycles", e.name, bus.done);
      return;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: %0d cycles required %0d", e.name, n, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles: %0d required %0d", e.name, busy_cnt, exp_busy);
    end
    checks++;
    if (bus.hi_out !== e.hi || bus.lo_out !== e.lo) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", e.name,
               bus.hi_out, bus.lo_out, e.hi, e.lo);
    end
    checks++;
    if ({bus.high_write, bus.low_write, bus.div_zero} !== {!e.dz, !e.dz, e.dz}) begin
      errors++;
      $display("FAIL %s strobes: hw/lw/dz=%b required %b", e.name,
               {bus.high_write, bus.low_write, bus.div_zero}, {!e.dz, !e.dz, e.dz});
    end
    if (!e.dz) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
    $display("txn %-14s hi=%h lo=%h dz=%b latency=%0d busy=%0d", e.name,
             bus.hi_out, bus.lo_out, bus.div_zero, n, busy_cnt);
  endtask

  task automatic run(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name,
                     input bit inject);
    logic edz;
    edz = (op == OP_DIV) && (b == '0);
    if (edz) issue(op, a, b, last_hi, last_lo, 1'b1, name);
    else     issue(op, a, b, ehi, elo, 1'b0, name);
    wait_done(inject, edz ? 1 : W + 1, edz ? 0 : W);
  endtask

  task automatic run_model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name);
    logic [W-1:0] ehi, elo;
    model(op, a, b, ehi, elo);
    run(op, a, b, ehi, elo, name, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.high_write, bus.low_write, bus.div_zero} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/hw/lw/dz=%b required 00000",
               {bus.busy, bus.done, bus.high_write, bus.low_write, bus.div_zero});
    end
    checks++;
    if (bus.hi_out !== '0 || bus.lo_out !== '0) begin
      errors++;
      $display("FAIL reset_data: hi=%h lo=%h required 0", bus.hi_out, bus.lo_out);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    $display("txn reset          outputs cleared");
  endtask

  task automatic test_mult();
    run(OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7x-3", 1'b0);
    for (int i = 0; i < 4; i++) run_model(OP_MULT, $urandom, $urandom, "mult_rand");
    run_model(OP_MULT, 32'd0, $urandom, "mult_zero");
  endtask

  task automatic test_div();
    logic [W-1:0] b;
    run(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7/-2", 1'b0);
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_-7/2", 1'b0);
    for (int i = 0; i < 3; i++) begin
      b = $urandom;
      if (b == '0) b = 32'd1;
      run_model(OP_DIV, $urandom, b, "div_rand");
    end
    for (int i = 0; i < 2; i++) begin
      b = W'($urandom_range(1, 40)) - 32'd20;
      if (b == '0) b = 32'd3;
      run_model(OP_DIV, W'($urandom_range(0, 2000)) - 32'd1000, b, "div_small");
    end
  endtask

  task automatic test_div_zero();
    run(OP_DIV, 32'd5, 32'd0, '0, '0, "div_5/0", 1'b0);
  endtask

  task automatic test_boundary();
    run(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min^2", 1'b0);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min/-1", 1'b0);
  endtask

  task automatic test_busy_start();
    run(OP_DIV, 32'd1000, 32'd7, 32'd6, 32'd142, "div_busy_start", 1'b1);
  endtask

  task automatic test_back_to_back();
    run(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "b2b_mult", 1'b0);
    run(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "b2b_div", 1'b0);
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, 32'd12345, 32'd11, 32'd3, 32'd1122, 1'b0, "div_aborted");
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.high_write, bus.low_write, bus.div_zero} !== 5'b0 ||
        bus.hi_out !== '0 || bus.lo_out !== '0) begin
      errors++;
      $display("FAIL async_reset: busy/done/hw/lw/dz=%b hi=%h lo=%h required all 0",
               {bus.busy, bus.done, bus.high_write, bus.low_write, bus.div_zero},
               bus.hi_out, bus.lo_out);
    end
    void'(sb_q.pop_back());
    last_hi = '0;
    last_lo = '0;
    $display("txn reset_mid_div  outputs cleared");
    #10 reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    run(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, "mult_3x4", 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_boundary();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Sequencer for the CPU's shared multiply/divide resource.
- Accepts a mult or div request from the main control unit, iterates an internal 32-step shift-add or restoring-division core, and pulses the write enables for the HI and LO registers.
- Flags divide-by-zero so the control unit can take the exception path.
- Sits between the control unit, the A/B operand registers and the HI/LO registers.

Parameters:
- WIDTH, 32, operand and result width (HI and LO are WIDTH each).
- CNT_W, 6, iteration counter width (must hold the value WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = signed mult, 1 = signed div; sampled with start.
- src_a  in  WIDTH  multiplicand or dividend; sampled with start.
- src_b  in  WIDTH  multiplier or divisor; sampled with start.
- busy  out  1  high in MULT and DIV states.
- done  out  1  one-cycle pulse at operation end, including the divide-by-zero case.
- high_write  out  1  one-cycle load enable for the HI register.
- low_write  out  1  one-cycle load enable for the LO register.
- hi_out  out  WIDTH  mult: upper product; div: remainder.
- lo_out  out  WIDTH  mult: lower product; div: quotient.
- div_zero  out  1  one-cycle pulse, coincident with done, when a div has src_b = 0.

Behaviour:
- Reset (reset = 0, any time, including mid-operation):
  - state goes to IDLE and the counter to 0.
  - Every output is 0: busy, done, high_write, low_write, div_zero, hi_out, lo_out.
  - Any in-flight operation is discarded.
- States are IDLE, MULT, DIV, DONE.
- IDLE:
  - start = 1, op = 0: latch operand magnitudes and the result sign (a[31]^b[31]); go to MULT.
  - start = 1, op = 1, src_b != 0: latch magnitudes; record quotient sign (a[31]^b[31]) and remainder sign (a[31]); go to DIV.
  - start = 1, op = 1, src_b = 0: go to DONE with the zero flag set.
  - start = 0: stay in IDLE.
- MULT: one shift-add step per cycle on the unsigned magnitudes into a 2*WIDTH accumulator. After WIDTH steps, apply two's-complement negation if the sign is set, load hi_out/lo_out, and go to DONE.
- DIV: one restoring step per cycle (shift remainder left, trial subtract, set quotient bit). After WIDTH steps, negate the quotient and remainder per their signs, load the outputs, and go to DONE.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - -2^31 / -1 yields lo = 0x80000000, hi = 0. No overflow flag.
- DONE, normal completion: done = 1, high_write = 1, low_write = 1, div_zero = 0 for exactly one cycle; then go to IDLE.
- DONE, zero flag set: done = 1, div_zero = 1, high_write = 0, low_write = 0; hi_out/lo_out keep their previous values; then go to IDLE.
- Latency:
  - start sampled at edge 0.
  - Mult/div: done is high in the cycle after edge WIDTH+1 (33 cycles for WIDTH = 32).
  - Divide-by-zero: done is high after edge 1.
- start while busy or in DONE is ignored and not queued. src_a/src_b changes after the start edge have no effect.
- hi_out/lo_out are registered and hold the last result until the next completion. They are valid when high_write/low_write are high and remain stable afterwards.
- The counter counts 0 to WIDTH-1 and clears when leaving MULT/DIV. It never wraps during an operation.

Decomposition:
- Shared package mult_div_pkg:
  - state enum (IDLE, MULT, DIV, DONE).
  - op codes OP_MULT = 1'b0, OP_DIV = 1'b1.
  - default WIDTH.
- One sub-module, mult_div_core:
  - holds the accumulator/remainder/quotient registers and the per-cycle step logic, selected by op.
  - mult_div_ctrl keeps the FSM, counter, sign capture, final negation and handshake outputs.

Test Plan:
- mult 7 x 0xFFFFFFFD (-3) -> done after 33 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; high_write = low_write = 1 for one cycle; busy high for 32 cycles.
- div 7 / 0xFFFFFFFE (-2) -> lo = 0xFFFFFFFD (-3), hi = 0x00000001; div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div 5 / 0 -> done and div_zero high after edge 1; high_write = low_write = 0; hi_out/lo_out unchanged from the prior result.
- mult 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000; div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- start pulsed at cycles 5 and 20 while busy, with different operands -> ignored; the result matches the first request only; a new start in IDLE is accepted.
- reset asserted at cycle 10 of a div -> all outputs 0 immediately (asynchronous); after release, a fresh mult 3 x 4 gives lo = 12, hi = 0.
